// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched
// Read-side scheduler for the FIR async FIFO, living entirely in rd_clk.
// It shares one FIFO read port between NUM_REQ consumers. One requester is
// granted at a time, and up to BURST_LEN words are read for it. Every
// returned word is tagged with the owner's ID.
//
// Ports:
//   rd_clk        read-domain clock, rising edge
//   rdst          synchronous active-high reset
//   req           per-requester level-held read request
//   fifo_empty    FIFO empty flag
//   fifo_rd_data  FIFO read data, valid one cycle after an accepted read
//   fifo_rd_en    FIFO read enable (combinational, only in BURST)
//   gnt           registered one-hot grant
//   out_valid     out_data/out_id valid this cycle
//   out_data      read word (fifo_rd_data passed through)
//   out_id        requester owning out_data
//   burst_done    one-cycle pulse in the cycle after a burst ends
//   burst_cnt     words read in the finished burst, valid with burst_done
//
// Build option:
//   FIFO_RD_SCHED_FIXPRI_EN  when defined, the lowest set req index always
//                            wins and the round-robin pointer is tied to 0.
//                            When undefined (default), arbitration is round-robin.
module fifo_rd_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                          rd_clk,
  input  logic                          rdst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
  output logic                          fifo_rd_en,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          burst_done,
  output logic [$clog2(BURST_LEN):0]    burst_cnt
);

  localparam int CNT_W  = $clog2(BURST_LEN) + 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int SCAN_W = ID_WIDTH + 1;

  localparam logic [CNT_W-1:0]   BURST_MAX = CNT_W'(BURST_LEN);
  localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(TIMEOUT);
  localparam logic [SCAN_W-1:0]  NUM_SCAN  = SCAN_W'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t              state;
  state_t              next_state;
  logic [ID_WIDTH-1:0] owner;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] arb_winner;
  logic [SCAN_W-1:0]   scan;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [TMR_W-1:0]    tmr;
  logic [TMR_W-1:0]    tmr_next;

  assign out_data = fifo_rd_data;

  // Round-robin search starting at rr_ptr. The loop walks from the lowest
  // priority position down to the highest, so the last hit is the winner.
  always_comb begin
    scan       = '0;
    arb_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan = {1'b0, rr_ptr} + SCAN_W'(i);
      if (scan >= NUM_SCAN) scan = scan - NUM_SCAN;
      if (req[scan[ID_WIDTH-1:0]]) arb_winner = scan[ID_WIDTH-1:0];
    end
  end

  // Next-state and read-enable logic. A dropped request ends the burst
  // before any read is issued. Otherwise the word count and empty timer
  // include this cycle's outcome when the exit conditions are evaluated.
  always_comb begin
    next_state = state;
    fifo_rd_en = 1'b0;
    cnt_next   = cnt;
    tmr_next   = tmr;
    case (state)
      IDLE: begin
        cnt_next = '0;
        tmr_next = '0;
        if (|req) next_state = BURST;
      end
      BURST: begin
        if (!req[owner]) begin
          next_state = DONE;
        end else begin
          fifo_rd_en = !fifo_empty && (cnt < BURST_MAX);
          if (fifo_rd_en) begin
            cnt_next = cnt + 1'b1;
            tmr_next = '0;
          end else if (fifo_empty) begin
            tmr_next = tmr + 1'b1;
          end
          if ((cnt_next == BURST_MAX) || (tmr_next == TMR_MAX)) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, grant, burst bookkeeping and the one-cycle-delayed data tag.
  always_ff @(posedge rd_clk) begin
    if (rdst) begin
      state      <= IDLE;
      gnt        <= '0;
      owner      <= '0;
      cnt        <= '0;
      tmr        <= '0;
      out_valid  <= 1'b0;
      out_id     <= '0;
      burst_done <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_next;
      tmr        <= tmr_next;
      out_valid  <= fifo_rd_en;
      burst_done <= (state == BURST) && (next_state == DONE);
      if (fifo_rd_en) out_id <= owner;
      if ((state == IDLE) && (next_state == BURST)) begin
        owner <= arb_winner;
        gnt   <= GNT_ONE << arb_winner;
      end
      if ((state == BURST) && (next_state == DONE)) begin
        gnt       <= '0;
        burst_cnt <= cnt_next;
      end
    end
  end

`ifdef FIFO_RD_SCHED_FIXPRI_EN
  // Fixed priority: the search always starts at index 0.
  assign rr_ptr = '0;
`else
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  // The pointer moves just past the owner when its burst finishes.
  always_ff @(posedge rd_clk) begin
    if (rdst) begin
      rr_ptr <= '0;
    end else if ((state == BURST) && (next_state == DONE)) begin
      rr_ptr <= (owner == LAST_ID) ? '0 : owner + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb_fifo_rd_sched
// Self-checking bench for fifo_rd_sched. A behavioural reference model
// tracks grant ownership, burst progress and expected outputs. A queue
// stands in for the FIFO contents. Directed scenarios are followed by a
// long randomized run.
module tb_fifo_rd_sched;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int BL = 4;
  localparam int TO = 8;
  localparam int CW = $clog2(BL) + 1;
`ifdef FIFO_RD_SCHED_FIXPRI_EN
  localparam bit FIXPRI = 1'b1;
`else
  localparam bit FIXPRI = 1'b0;
`endif

  logic          rd_clk = 1'b0;
  logic          rdst = 1'b1;
  logic [NR-1:0] req = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic [NR-1:0] gnt;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;
  logic          burst_done;
  logic [CW-1:0] burst_cnt;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_sched #(
    .DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .rd_clk(rd_clk), .rdst(rdst), .req(req), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .gnt(gnt),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .burst_done(burst_done), .burst_cnt(burst_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] fifoq[$];

  // Reference model state
  bit            m_granted;
  bit            m_gap;
  int            m_owner;
  int            m_words;
  int            m_quiet;
  int            m_start;
  logic [NR-1:0] e_gnt;
  bit            e_valid;
  bit            e_done;
  int            e_id;
  int            e_bcnt;
  logic [DW-1:0] e_data;
  int            model_sum[NR];

  // Observations of the DUT used by the directed scenarios
  int            dut_words[NR];
  int            grant_log[$];
  logic [NR-1:0] prev_gnt;
  int            rd_seen;
  int            done_count;
  int            last_bcnt;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pickWinner(input logic [NR-1:0] r, input int start);
    for (int k = 0; k < NR; k++) begin
      int idx = (start + k) % NR;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic modelEdge(input logic [NR-1:0] r, input bit rst, input bit rd);
    bit fin;
    if (rst) begin
      m_granted = 0; m_gap = 0; m_owner = 0; m_words = 0; m_quiet = 0; m_start = 0;
      e_gnt = '0; e_valid = 0; e_done = 0; e_id = 0; e_bcnt = 0;
      return;
    end
    e_valid = rd;
    if (rd) e_id = m_owner;
    e_done = 0;
    fin = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_granted) begin
      if (!r[m_owner]) begin
        fin = 1;
      end else begin
        if (rd) begin
          m_words++;
          m_quiet = 0;
        end else if (fifo_empty) begin
          m_quiet++;
        end
        if (m_words == BL || m_quiet == TO) fin = 1;
      end
      if (fin) begin
        m_granted = 0;
        m_gap = 1;
        e_gnt = '0;
        e_done = 1;
        e_bcnt = m_words;
        model_sum[m_owner] += m_words;
        m_start = FIXPRI ? 0 : (m_owner + 1) % NR;
      end
    end else if (r != 0) begin
      m_owner = pickWinner(r, m_start);
      m_granted = 1;
      m_words = 0;
      m_quiet = 0;
      e_gnt = NR'(1) << m_owner;
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic applyStimulus(input logic [NR-1:0] r, input int push, input bit rst);
    bit exp_rd;
    bit dut_rd;
    bit did_pop;
    logic [DW-1:0] popped;
    rdst = rst;
    req = r;
    for (int k = 0; k < push; k++) fifoq.push_back(DW'($urandom));
    fifo_empty = (fifoq.size() == 0);
    #1;
    exp_rd = m_granted && r[m_owner] && !fifo_empty && (m_words < BL);
    checkOutput("gnt", 32'(gnt), 32'(e_gnt));
    checkOutput("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    checkOutput("out_valid", 32'(out_valid), 32'(e_valid));
    checkOutput("out_id", 32'(out_id), 32'(e_id));
    checkOutput("burst_done", 32'(burst_done), 32'(e_done));
    if (e_done) checkOutput("burst_cnt", 32'(burst_cnt), 32'(e_bcnt));
    if (e_valid) checkOutput("out_data", 32'(out_data), 32'(e_data));
    checkOutput("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 32'(0));
    checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
    if (gnt != 0 && prev_gnt == 0) begin
      for (int k = 0; k < NR; k++) if (gnt[k]) grant_log.push_back(k);
    end
    prev_gnt = gnt;
    if (out_valid) dut_words[out_id]++;
    if (fifo_rd_en) rd_seen++;
    if (burst_done) begin
      done_count++;
      last_bcnt = int'(burst_cnt);
    end
    dut_rd = fifo_rd_en;
    @(posedge rd_clk);
    did_pop = 0;
    popped = '0;
    if (exp_rd && fifoq.size() > 0) e_data = fifoq[0];
    if (dut_rd && fifoq.size() > 0) begin
      popped = fifoq.pop_front();
      did_pop = 1;
    end
    modelEdge(r, rst, exp_rd);
    @(negedge rd_clk);
    fifo_rd_data = did_pop ? popped : DW'($urandom);
  endtask

  task automatic restart();
    fifoq.delete();
    applyStimulus('0, 0, 1'b1);
    grant_log.delete();
    rd_seen = 0;
    done_count = 0;
    last_bcnt = -1;
  endtask

  initial begin
    logic [NR-1:0] r;
    prev_gnt = '0;
    for (int i = 0; i < NR; i++) begin
      dut_words[i] = 0;
      model_sum[i] = 0;
    end
    modelEdge('0, 1'b1, 1'b0);
    rdst = 1'b1;
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);

    // Single requester, plenty of data: one full burst, gap, re-grant.
    $display("[TB] scenario 1: single requester full burst");
    restart();
    checkOutput("burst_cnt_rst", 32'(burst_cnt), 32'(0));
    applyStimulus(4'b0001, 10, 0);
    repeat (5) applyStimulus(4'b0001, 0, 0);
    checkOutput("t1_reads", 32'(rd_seen), 32'(4));
    checkOutput("t1_done", 32'(done_count), 32'(1));
    checkOutput("t1_bcnt", 32'(last_bcnt), 32'(4));
    repeat (2) applyStimulus(4'b0001, 0, 0);
    checkOutput("t1_grants", 32'(grant_log.size()), 32'(2));
    checkOutput("t1_regrant", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'(0));

    // All requesting, FIFO never empty: rotation of grants.
    $display("[TB] scenario 2: all requesters");
    restart();
    applyStimulus(4'b1111, 4, 0);
    repeat (29) applyStimulus(4'b1111, 1, 0);
    checkOutput("t2_grants", 32'(grant_log.size()), 32'(5));
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2_grant%0d", i),
                  32'(grant_log.size() > i ? grant_log[i] : -1),
                  32'(FIXPRI ? 0 : i % NR));
    end

    // Two words then starvation: timeout ends the burst.
    $display("[TB] scenario 3: empty timeout");
    restart();
    applyStimulus(4'b0100, 2, 0);
    repeat (11) applyStimulus(4'b0100, 0, 0);
    checkOutput("t3_reads", 32'(rd_seen), 32'(2));
    checkOutput("t3_done", 32'(done_count), 32'(1));
    checkOutput("t3_bcnt", 32'(last_bcnt), 32'(2));
    applyStimulus(4'b1111, 4, 0);
    applyStimulus(4'b1111, 0, 0);
    checkOutput("t3_next", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'(FIXPRI ? 0 : 3));

    // Request dropped after one accepted read.
    $display("[TB] scenario 4: request dropped");
    restart();
    for (int i = 0; i < NR; i++) dut_words[i] = 0;
    applyStimulus(4'b0010, 3, 0);
    applyStimulus(4'b0010, 0, 0);
    repeat (3) applyStimulus(4'b0000, 0, 0);
    checkOutput("t4_reads", 32'(rd_seen), 32'(1));
    checkOutput("t4_bcnt", 32'(last_bcnt), 32'(1));
    checkOutput("t4_words_id1", 32'(dut_words[1]), 32'(1));

    // Reset in the middle of a burst; arbitration restarts from index 0.
    $display("[TB] scenario 5: reset mid-burst");
    grant_log.delete();
    rd_seen = 0;
    done_count = 0;
    applyStimulus(4'b1010, 4, 0);
    repeat (2) applyStimulus(4'b1010, 0, 0);
    applyStimulus(4'b1010, 0, 1);
    applyStimulus(4'b1010, 0, 0);
    checkOutput("t5_rst_valid", 32'(out_valid), 32'(0));
    applyStimulus(4'b1010, 0, 0);
    checkOutput("t5_no_done", 32'(done_count), 32'(0));
    checkOutput("t5_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'(FIXPRI ? 1 : 3));
    checkOutput("t5_after_rst", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'(1));

    // Randomized traffic, then drain so every burst completes.
    $display("[TB] scenario 6: random traffic");
    restart();
    for (int i = 0; i < NR; i++) begin
      dut_words[i] = 0;
      model_sum[i] = 0;
    end
    r = NR'($urandom);
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(7) == 0) r = NR'($urandom);
      applyStimulus(r, ($urandom_range(9) < 6) ? 1 : 0, 0);
    end
    repeat (20) applyStimulus('0, 0, 0);
    for (int i = 0; i < NR; i++) begin
      checkOutput($sformatf("t6_words_id%0d", i), 32'(dut_words[i]), 32'(model_sum[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
